mlaccel_memarb: RTL and testbench
=================================

MLACCEL_MEMARB -- requirements
Module: mlaccel_memarb

Interface
REQ-001 Parameter RD_LATENCY, default 2: cycles from an accepted read to its rvalid; legal range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 15: wait cycles before the starvation guard forces a grant; legal range 1..255.
REQ-003 Port clock  in  1  clock, rising edge only.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Ports c_ren in 1, c_wen in 8, c_addr in 16, c_wdata in 64: compute port; a request is c_ren or any c_wen bit.
REQ-006 Port c_stall  out  1  compute request not serviced this cycle; compute holds its request.
REQ-007 Ports c_rvalid out 1, c_rdata out 64: compute read return.
REQ-008 Ports q_valid in 1, q_ready out 1, q_wen in 8, q_addr in 16, q_wdata in 64: host (QPI) port; q_wen==0 means read.
REQ-009 Ports q_rvalid out 1, q_rdata out 16: host read return, mem_rdata[15:0].
REQ-010 Ports s_valid in 1, s_ready out 1, s_addr in 16: sequencer port, read-only.
REQ-011 Ports s_rvalid out 1, s_rdata out 32: sequencer read return, mem_rdata[31:0].
REQ-012 Ports mem_addr out 16, mem_wen out 8, mem_wdata out 64, mem_rdata in 64: memory macro side; mem_rdata is valid RD_LATENCY cycles after the address cycle.

Function
REQ-013 Grant is combinational within one cycle; fixed priority: compute > host > sequencer, except when overridden by REQ-021.
REQ-014 q_ready / s_ready are high exactly in cycles where that port is granted; a transfer occurs on valid && ready.
REQ-015 Requesters hold valid, address, wen and wdata stable until ready; the arbiter does not register requests.
REQ-016 Granted port drives mem_addr/mem_wen/mem_wdata in the same cycle; sequencer grant drives mem_wen=0.
REQ-017 With no grant: mem_wen=0, mem_addr=c_addr, mem_wdata=c_wdata.
REQ-018 Each granted read pushes a one-hot tag {c,q,s} into a RD_LATENCY-deep shift register; the tag at its output asserts the matching rvalid for exactly one cycle. Writes push an all-zero tag.
REQ-019 Reads from different ports may be back-to-back every cycle; returns appear in grant order, never merged or dropped.
REQ-020 c_rdata, q_rdata and s_rdata are continuous slices of mem_rdata; their contents are meaningful only while the matching rvalid is high.

Reset
REQ-021 Starvation override: see REQ-026.
REQ-022 On reset: tag pipeline cleared, all rvalid=0, starvation counters=0, c_stall=0 the following cycle.
REQ-023 Reset mid-operation discards in-flight read tags; no rvalid is asserted for reads accepted before reset.
REQ-024 During reset cycles q_ready=s_ready=0 and mem_wen=0.

Configuration
REQ-025 Macro MLACCEL_MEMARB_STARVE_GUARD_EN enables the starvation guard.
REQ-026 With it: an 8-bit counter per host/sequencer port increments each cycle valid && !ready and saturates at STARVE_LIMIT; clears on transfer or when valid is low. At the limit, if compute requests, compute is stalled (c_stall=1) and that port is granted. If both are at the limit, host wins.
REQ-027 Without it: no counters; c_stall is constant 0; compute always wins.

Verification
REQ-028 c_ren and q_valid both active in the same cycle, c_addr=0x0010, q_addr=0x0020 -> compute granted, q_ready=0. After compute drops, q_ready=1 at 0x0020. q_rvalid follows 2 cycles later with q_rdata=mem[0x0020][15:0].
REQ-029 Host write q_wen=0x03, q_addr=0x0100, q_wdata=0xBEEF, then sequencer read at 0x0100 -> s_rvalid with s_rdata[15:0]=0xBEEF.
REQ-030 Alternating host and sequencer reads every cycle, 8 total -> 8 rvalid pulses in grant order at latency 2 with no gaps.
REQ-031 Guard enabled, compute requests continuously, s_valid held -> s_ready=1 and c_stall=1 on wait cycle 15. The counter then clears. Guard disabled -> s_ready stays 0.
REQ-032 Reset asserted 1 cycle after a host read grant -> no q_rvalid appears; all outputs are at reset values.

Source files
------------

// File: rtl/mlaccel_memarb.sv
`default_nettype none
// mlaccel_memarb: compute > host > sequencer arbiter for one shared memory macro, with a read-return tag pipeline.
// Define MLACCEL_MEMARB_STARVE_GUARD_EN to let a starved host/sequencer request pre-empt compute.
module mlaccel_memarb #(
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_c_ren,
  input  logic [7:0]  i_c_wen,
  input  logic [15:0] i_c_addr,
  input  logic [63:0] i_c_wdata,
  output logic        o_c_stall,
  output logic        o_c_rvalid,
  output logic [63:0] o_c_rdata,
  input  logic        i_q_valid,
  output logic        o_q_ready,
  input  logic [7:0]  i_q_wen,
  input  logic [15:0] i_q_addr,
  input  logic [63:0] i_q_wdata,
  output logic        o_q_rvalid,
  output logic [15:0] o_q_rdata,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [15:0] i_s_addr,
  output logic        o_s_rvalid,
  output logic [31:0] o_s_rdata,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wen,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata
);

  localparam logic [2:0] TAG_NONE = 3'b000;
  localparam logic [2:0] TAG_C    = 3'b100;
  localparam logic [2:0] TAG_Q    = 3'b010;
  localparam logic [2:0] TAG_S    = 3'b001;

  // Parameter values outside the supported ranges elaborate to nothing useful.
  if (RD_LATENCY < 1 || RD_LATENCY > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_out_of_range
  end

  logic       w_c_req;
  logic       w_q_force;
  logic       w_s_force;
  logic       w_grant_c;
  logic       w_grant_q;
  logic       w_grant_s;
  logic [2:0] w_tag;
  logic [2:0] r_tag [RD_LATENCY];

  assign w_c_req = i_c_ren | (|i_c_wen);

`ifdef MLACCEL_MEMARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_q_wait;
  logic [7:0] r_s_wait;

  // Host outranks the sequencer when both have waited out the limit.
  assign w_q_force = w_c_req & i_q_valid & (r_q_wait == LIMIT);
  assign w_s_force = w_c_req & i_s_valid & (r_s_wait == LIMIT) & ~w_q_force;
  assign o_c_stall = ~reset & w_c_req & ~w_grant_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_wait <= '0;
      r_s_wait <= '0;
    end else begin
      if (!i_q_valid || w_grant_q)
        r_q_wait <= '0;
      else if (r_q_wait != LIMIT)
        r_q_wait <= r_q_wait + 8'd1;
      if (!i_s_valid || w_grant_s)
        r_s_wait <= '0;
      else if (r_s_wait != LIMIT)
        r_s_wait <= r_s_wait + 8'd1;
    end
  end
`else
  assign w_q_force = 1'b0;
  assign w_s_force = 1'b0;
  assign o_c_stall = 1'b0;
`endif

  assign w_grant_c = ~reset & w_c_req & ~w_q_force & ~w_s_force;
  assign w_grant_q = ~reset & (w_q_force | (~w_c_req & i_q_valid));
  assign w_grant_s = ~reset & (w_s_force | (~w_c_req & ~i_q_valid & i_s_valid));

  assign o_q_ready = w_grant_q;
  assign o_s_ready = w_grant_s;

  always_comb begin
    o_mem_addr  = i_c_addr;
    o_mem_wen   = 8'd0;
    o_mem_wdata = i_c_wdata;
    w_tag       = TAG_NONE;
    if (w_grant_c) begin
      o_mem_wen = i_c_wen;
      w_tag     = (i_c_wen == 8'd0) ? TAG_C : TAG_NONE;
    end else if (w_grant_q) begin
      o_mem_addr  = i_q_addr;
      o_mem_wen   = i_q_wen;
      o_mem_wdata = i_q_wdata;
      w_tag       = (i_q_wen == 8'd0) ? TAG_Q : TAG_NONE;
    end else if (w_grant_s) begin
      o_mem_addr = i_s_addr;
      w_tag      = TAG_S;
    end
  end

  // The tag leaving the last stage lines up with mem_rdata for that read.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++)
        r_tag[i] <= TAG_NONE;
    end else begin
      r_tag[0] <= w_tag;
      for (int i = 1; i < RD_LATENCY; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_c_rvalid = ~reset & r_tag[RD_LATENCY-1][2];
  assign o_q_rvalid = ~reset & r_tag[RD_LATENCY-1][1];
  assign o_s_rvalid = ~reset & r_tag[RD_LATENCY-1][0];

  assign o_c_rdata = i_mem_rdata;
  assign o_q_rdata = i_mem_rdata[15:0];
  assign o_s_rdata = i_mem_rdata[31:0];

endmodule
`default_nettype wire

// File: tb/tb_mlaccel_memarb.sv
`default_nettype none
// tb_mlaccel_memarb: directed and randomized checks against a transaction-level model of the arbiter.
module tb_mlaccel_memarb;

  localparam int LAT    = 2;
  localparam int SL     = 15;
  localparam int G_NONE = 0;
  localparam int G_C    = 1;
  localparam int G_Q    = 2;
  localparam int G_S    = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_ren, q_valid, s_valid;
  logic [7:0]  c_wen, q_wen;
  logic [15:0] c_addr, q_addr, s_addr;
  logic [63:0] c_wdata, q_wdata;
  logic        c_stall, c_rvalid, q_ready, q_rvalid, s_ready, s_rvalid;
  logic [63:0] c_rdata, mem_wdata, mem_rdata;
  logic [15:0] q_rdata, mem_addr;
  logic [31:0] s_rdata;
  logic [7:0]  mem_wen;

  always #5 clock = ~clock;

  mlaccel_memarb #(.RD_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .i_c_ren(c_ren), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_stall(c_stall), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_q_valid(q_valid), .o_q_ready(q_ready), .i_q_wen(q_wen), .i_q_addr(q_addr),
    .i_q_wdata(q_wdata), .o_q_rvalid(q_rvalid), .o_q_rdata(q_rdata),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_addr(s_addr),
    .o_s_rvalid(s_rvalid), .o_s_rdata(s_rdata),
    .o_mem_addr(mem_addr), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Memory macro: read-first, data valid LAT cycles after the address cycle.
  logic [63:0] env_mem [65536];
  logic [63:0] rd_pipe [LAT];
  logic [63:0] merged;
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clock) begin
    rd_pipe[0] <= env_mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    merged = env_mem[mem_addr];
    for (int b = 0; b < 8; b++) if (mem_wen[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    if (mem_wen != 8'd0) env_mem[mem_addr] <= merged;
  end

  typedef struct { int port; logic [63:0] data; int due; } ret_t;
  ret_t        ret_q[$];
  logic [63:0] ref_mem [65536];
  int          qwait, swait, cyc, passed, total, exp_g;
  logic        obs_q_ready, obs_s_ready, obs_q_rvalid, obs_s_rvalid, obs_c_rvalid;
  logic [15:0] obs_q_rdata;
  logic [31:0] obs_s_rdata;

  function automatic logic [63:0] pattern(int a);
    logic [15:0] x;
    x = 16'(a);
    return {x, ~x, x ^ 16'h5A5A, x + 16'h1234};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int model_grant();
    bit creq;
    creq = c_ren || (c_wen != 8'd0);
    if (reset) return G_NONE;
`ifdef MLACCEL_MEMARB_STARVE_GUARD_EN
    if (creq && q_valid && qwait >= SL) return G_Q;
    if (creq && s_valid && swait >= SL) return G_S;
`endif
    if (creq) return G_C;
    if (q_valid) return G_Q;
    if (s_valid) return G_S;
    return G_NONE;
  endfunction

  task automatic tick();
    int g, rp;
    bit creq;
    logic [15:0] ea;
    logic [7:0]  ew;
    logic [63:0] ed, rdat;
    ret_t e;
    @(negedge clock);
    creq = c_ren || (c_wen != 8'd0);
    g = model_grant();
    obs_q_ready = q_ready; obs_s_ready = s_ready;
    obs_c_rvalid = c_rvalid; obs_q_rvalid = q_rvalid; obs_s_rvalid = s_rvalid;
    obs_q_rdata = q_rdata; obs_s_rdata = s_rdata;
    chk("q_ready", 64'(q_ready), 64'(g == G_Q));
    chk("s_ready", 64'(s_ready), 64'(g == G_S));
    chk("c_stall", 64'(c_stall), 64'(!reset && creq && g != G_C));
    case (g)
      G_C:     begin ea = c_addr; ew = c_wen; ed = c_wdata; end
      G_Q:     begin ea = q_addr; ew = q_wen; ed = q_wdata; end
      G_S:     begin ea = s_addr; ew = 8'd0;  ed = c_wdata; end
      default: begin ea = c_addr; ew = 8'd0;  ed = c_wdata; end
    endcase
    chk("mem_wen", 64'(mem_wen), 64'(ew));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    if (g != G_S) chk("mem_wdata", mem_wdata, ed);
    rp = G_NONE;
    rdat = '0;
    if (!reset && ret_q.size() > 0 && ret_q[0].due == cyc) begin
      rp = ret_q[0].port;
      rdat = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    chk("c_rvalid", 64'(c_rvalid), 64'(rp == G_C));
    chk("q_rvalid", 64'(q_rvalid), 64'(rp == G_Q));
    chk("s_rvalid", 64'(s_rvalid), 64'(rp == G_S));
    if (rp == G_C) chk("c_rdata", c_rdata, rdat);
    if (rp == G_Q) chk("q_rdata", 64'(q_rdata), 64'(rdat[15:0]));
    if (rp == G_S) chk("s_rdata", 64'(s_rdata), 64'(rdat[31:0]));
    if (reset) begin
      ret_q.delete();
      qwait = 0;
      swait = 0;
    end else begin
      if (g != G_NONE && ew == 8'd0) begin
        e.port = g; e.data = ref_mem[ea]; e.due = cyc + LAT;
        ret_q.push_back(e);
      end else begin
        for (int b = 0; b < 8; b++) if (ew[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
      end
      qwait = (q_valid && g != G_Q) ? qwait + 1 : 0;
      swait = (s_valid && g != G_S) ? swait + 1 : 0;
    end
    exp_g = g;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int cnt, first, last, exp_first;
    logic [63:0] got;
    for (int a = 0; a < 65536; a++) begin
      env_mem[a] = pattern(a);
      ref_mem[a] = pattern(a);
    end
    passed = 0; total = 0; cyc = 0; qwait = 0; swait = 0; exp_g = G_NONE;
    c_ren = 0; c_wen = 0; c_addr = 0; c_wdata = 0;
    q_valid = 0; q_wen = 0; q_addr = 0; q_wdata = 0;
    s_valid = 0; s_addr = 0;

    // Reset with host write and sequencer read pending.
    reset = 1; q_valid = 1; q_wen = 8'hFF; s_valid = 1;
    repeat (2) tick();
    reset = 0; q_valid = 0; q_wen = 0; s_valid = 0;
    tick();

    // Compute beats host, host follows.
    c_ren = 1; c_addr = 16'h0010; q_valid = 1; q_addr = 16'h0020;
    tick();
    c_ren = 0;
    tick();
    q_valid = 0;
    got = '0;
    repeat (4) begin tick(); if (obs_q_rvalid) got = 64'(obs_q_rdata); end
    chk("host_read_0x20", got, 64'h1254);

    // Host partial write, sequencer read-back.
    q_valid = 1; q_wen = 8'h03; q_addr = 16'h0100; q_wdata = 64'hBEEF;
    tick();
    q_valid = 0; q_wen = 0; s_valid = 1; s_addr = 16'h0100;
    tick();
    s_valid = 0;
    got = '0;
    repeat (4) begin tick(); if (obs_s_rvalid) got = 64'(obs_s_rdata); end
    chk("seq_readback", 64'(got[15:0]), 64'hBEEF);

    // Alternating host/sequencer reads back to back.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      q_valid = (i < 8) && (i % 2 == 0);
      s_valid = (i < 8) && (i % 2 == 1);
      q_addr = 16'(16'h0200 + i);
      s_addr = 16'(16'h0300 + i);
      tick();
      if (obs_q_rvalid || obs_s_rvalid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("alt_pulse_count", 64'(cnt), 64'd8);
    chk("alt_first_pulse", 64'(first), 64'(LAT));
    chk("alt_pulse_span", 64'(last - first), 64'd7);

    // Continuous compute against a held sequencer request.
`ifdef MLACCEL_MEMARB_STARVE_GUARD_EN
    exp_first = SL;
`else
    exp_first = -1;
`endif
    c_ren = 1; c_addr = 16'h0040; s_valid = 1; s_addr = 16'h0044;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_s_ready && first < 0) first = i;
    end
    c_ren = 0; s_valid = 0;
    chk("starve_grant_cycle", 64'(first), 64'(exp_first));
    repeat (4) tick();

    // Reset one cycle after a host read grant.
    q_valid = 1; q_addr = 16'h0020;
    tick();
    q_valid = 0; reset = 1;
    repeat (2) tick();
    reset = 0;
    cnt = 0;
    repeat (4) begin tick(); if (obs_q_rvalid || obs_c_rvalid || obs_s_rvalid) cnt++; end
    chk("no_rvalid_after_reset", 64'(cnt), 64'd0);

    // Randomized traffic; requesters hold until granted.
    for (int n = 0; n < 300; n++) begin
      if (!((c_ren || c_wen != 8'd0) && exp_g != G_C)) begin
        case ($urandom_range(0, 3))
          0: begin c_ren = 0; c_wen = 0; end
          2: begin c_ren = 0; c_wen = 8'($urandom_range(1, 255)); end
          default: begin c_ren = 1; c_wen = 0; end
        endcase
        c_addr = 16'($urandom_range(0, 63));
        c_wdata = {$urandom, $urandom};
      end
      if (!(q_valid && exp_g != G_Q)) begin
        q_valid = $urandom_range(0, 1) == 1;
        q_wen = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
        q_addr = 16'($urandom_range(0, 63));
        q_wdata = {$urandom, $urandom};
      end
      if (!(s_valid && exp_g != G_S)) begin
        s_valid = $urandom_range(0, 1) == 1;
        s_addr = 16'($urandom_range(0, 63));
      end
      tick();
    end
    c_ren = 0; c_wen = 0; q_valid = 0; q_wen = 0; s_valid = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
